// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus arbiter.
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } bus_arb_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after the last winner, wrapping.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int N    = 3,
  parameter int IdxW = idx_w(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] last_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IdxW'((int'(last_i) + k) % N);
      if (!valid_o && req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin single-outstanding interconnect: N hosts to M address-mapped devices,
// with decode-error and timeout responses generated locally.
module bus_arbiter_rr
  import bus_arb_pkg::*;
#(
  parameter int NrHosts       = 3,
  parameter int NrDevices     = 2,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NrHosts-1:0]      host_req_i,
  output logic [NrHosts-1:0]      host_gnt_o,
  input  logic [AddressWidth-1:0] host_addr_i  [NrHosts],
  input  logic [NrHosts-1:0]      host_we_i,
  input  logic [DataWidth/8-1:0]  host_be_i    [NrHosts],
  input  logic [DataWidth-1:0]    host_wdata_i [NrHosts],
  output logic [NrHosts-1:0]      host_rvalid_o,
  output logic [DataWidth-1:0]    host_rdata_o [NrHosts],
  output logic [NrHosts-1:0]      host_err_o,
  output logic [NrDevices-1:0]    device_req_o,
  output logic [AddressWidth-1:0] device_addr_o  [NrDevices],
  output logic [NrDevices-1:0]    device_we_o,
  output logic [DataWidth/8-1:0]  device_be_o    [NrDevices],
  output logic [DataWidth-1:0]    device_wdata_o [NrDevices],
  input  logic [NrDevices-1:0]    device_rvalid_i,
  input  logic [DataWidth-1:0]    device_rdata_i [NrDevices],
  input  logic [NrDevices-1:0]    device_err_i,
  input  logic [AddressWidth-1:0] cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0] cfg_device_addr_mask [NrDevices]
);

  localparam int HostIdxW = idx_w(NrHosts);
  localparam int DevIdxW  = idx_w(NrDevices);
  localparam int CntW     = $clog2(TimeoutCycles);
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

  bus_arb_state_e      state_q, state_d;
  logic                ready_q, ready_d;
  logic [HostIdxW-1:0] rr_q, rr_d;
  logic [HostIdxW-1:0] host_q, host_d;
  logic [DevIdxW-1:0]  dev_q, dev_d;
  logic                derr_q, derr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                pick_valid;
  logic [HostIdxW-1:0] pick_idx;
  logic [AddressWidth-1:0] win_addr;
  logic                dec_hit;
  logic [DevIdxW-1:0]  dec_idx;
  logic                resp_done;
  logic                grant_en;

  rr_pick #(
    .N    (NrHosts),
    .IdxW (HostIdxW)
  ) u_rr_pick (
    .req_i   (host_req_i),
    .last_i  (rr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Scan downward so the lowest matching device index wins on overlap.
  always_comb begin
    win_addr = host_addr_i[pick_idx];
    dec_hit  = 1'b0;
    dec_idx  = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((win_addr & cfg_device_addr_mask[DevIdxW'(d)]) == cfg_device_addr_base[DevIdxW'(d)]) begin
        dec_hit = 1'b1;
        dec_idx = DevIdxW'(d);
      end
    end
  end

  always_comb begin
    host_gnt_o     = '0;
    host_rvalid_o  = '0;
    host_err_o     = '0;
    host_rdata_o   = '{default: '0};
    device_req_o   = '0;
    device_we_o    = '0;
    device_addr_o  = '{default: '0};
    device_be_o    = '{default: '0};
    device_wdata_o = '{default: '0};
    state_d   = state_q;
    ready_d   = 1'b1;
    rr_d      = rr_q;
    host_d    = host_q;
    dev_d     = dev_q;
    derr_d    = derr_q;
    cnt_d     = cnt_q;
    resp_done = 1'b0;

    if (state_q == WAIT) begin
      if (derr_q) begin
        host_rvalid_o[host_q] = 1'b1;
        host_err_o[host_q]    = 1'b1;
        resp_done             = 1'b1;
      end else if (device_rvalid_i[dev_q]) begin
        host_rvalid_o[host_q] = 1'b1;
        host_err_o[host_q]    = device_err_i[dev_q];
        host_rdata_o[host_q]  = device_rdata_i[dev_q];
        resp_done             = 1'b1;
      end else if (cnt_q == CntLast) begin
        host_rvalid_o[host_q] = 1'b1;
        host_err_o[host_q]    = 1'b1;
        resp_done             = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (resp_done) state_d = IDLE;

    // A completing response frees the bus for a same-cycle grant.
    grant_en = ready_q && ((state_q == IDLE) || resp_done);
    if (grant_en && pick_valid) begin
      host_gnt_o[pick_idx] = 1'b1;
      rr_d    = pick_idx;
      host_d  = pick_idx;
      cnt_d   = '0;
      state_d = WAIT;
      if (dec_hit) begin
        device_req_o[dec_idx]   = 1'b1;
        device_addr_o[dec_idx]  = win_addr;
        device_we_o[dec_idx]    = host_we_i[pick_idx];
        device_be_o[dec_idx]    = host_be_i[pick_idx];
        device_wdata_o[dec_idx] = host_wdata_i[pick_idx];
        dev_d  = dec_idx;
        derr_d = 1'b0;
      end else begin
        derr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      rr_q    <= HostIdxW'(NrHosts - 1);
      host_q  <= '0;
      dev_q   <= '0;
      derr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rr_q    <= rr_d;
      host_q  <= host_d;
      dev_q   <= dev_d;
      derr_q  <= derr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed vectors, corner sequences and random traffic vs a deadline-based model.
module tb_bus_arbiter_rr;

  localparam int NH = 3;
  localparam int ND = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  logic [NH-1:0]   host_req;
  logic [NH-1:0]   host_gnt;
  logic [AW-1:0]   h_addr  [NH];
  logic [NH-1:0]   h_we;
  logic [DW/8-1:0] h_be    [NH];
  logic [DW-1:0]   h_wdata [NH];
  logic [NH-1:0]   host_rvalid;
  logic [DW-1:0]   host_rdata [NH];
  logic [NH-1:0]   host_err;
  logic [ND-1:0]   device_req;
  logic [AW-1:0]   d_addr  [ND];
  logic [ND-1:0]   d_we;
  logic [DW/8-1:0] d_be    [ND];
  logic [DW-1:0]   d_wdata [ND];
  logic [ND-1:0]   dev_rvalid;
  logic [DW-1:0]   dev_rdata [ND];
  logic [ND-1:0]   dev_err;
  logic [AW-1:0]   cfg_base [ND];
  logic [AW-1:0]   cfg_mask [ND];

  bus_arbiter_rr #(
    .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(TO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .host_req_i(host_req), .host_gnt_o(host_gnt),
    .host_addr_i(h_addr), .host_we_i(h_we), .host_be_i(h_be), .host_wdata_i(h_wdata),
    .host_rvalid_o(host_rvalid), .host_rdata_o(host_rdata), .host_err_o(host_err),
    .device_req_o(device_req), .device_addr_o(d_addr), .device_we_o(d_we),
    .device_be_o(d_be), .device_wdata_o(d_wdata),
    .device_rvalid_i(dev_rvalid), .device_rdata_i(dev_rdata), .device_err_i(dev_err),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask)
  );

  // Device stubs: fixed latency per device, latency 0 means never respond.
  int lat  [ND];
  int pend [ND];
  logic [AW-1:0] cap [ND];

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int d = 0; d < ND; d++) begin
        pend[d] <= 0;
        cap[d]  <= '0;
      end
    end else begin
      for (int d = 0; d < ND; d++) begin
        if (device_req[d]) begin
          pend[d] <= lat[d];
          cap[d]  <= d_addr[d];
        end else if (pend[d] > 0) begin
          pend[d] <= pend[d] - 1;
        end
      end
    end
  end

  always_comb begin
    for (int d = 0; d < ND; d++) dev_rvalid[d] = (pend[d] == 1);
    dev_rdata[0] = cap[0] * 32'd3 + 32'h1234;
    dev_err[0]   = 1'b0;
    dev_rdata[1] = ~cap[1];
    dev_err[1]   = cap[1][2];
  end

  function automatic logic [DW-1:0] ram_data(input logic [AW-1:0] a);
    return a * 32'd3 + 32'h1234;
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction with a known completion cycle.
  int   cyc = 0;
  bit   m_ready, m_busy, m_err, m_we;
  int   m_host, m_done, m_last;
  logic [DW-1:0] m_data;
  logic [NH-1:0] last_gnt;

  task automatic tick_begin();
    logic [NH-1:0] eg, erv;
    logic [ND-1:0] edr;
    int win, dv, rh;
    bit rsp, rerr, rwe;
    logic [DW-1:0] rdat;
    #1;
    last_gnt = host_gnt;
    if (!rst_ni) begin
      chk("rst_gnt", 64'(host_gnt), 64'(0));
      chk("rst_rvalid", 64'(host_rvalid), 64'(0));
      chk("rst_err", 64'(host_err), 64'(0));
      chk("rst_dreq", 64'(device_req), 64'(0));
      for (int h = 0; h < NH; h++) chk("rst_rdata", 64'(host_rdata[h]), 64'(0));
      for (int d = 0; d < ND; d++) chk("rst_daddr", {d_addr[d], d_wdata[d]}, 64'(0));
      m_busy = 0; m_ready = 0; m_last = NH - 1;
      return;
    end
    rsp  = m_busy && (cyc == m_done);
    rh   = m_host; rerr = m_err; rdat = m_data; rwe = m_we;
    erv  = '0;
    if (rsp) erv[rh] = 1'b1;
    eg = '0; edr = '0; win = -1; dv = -1;
    if (m_ready && (!m_busy || rsp)) begin
      for (int k = 1; k <= NH; k++)
        if (win < 0 && host_req[(m_last + k) % NH]) win = (m_last + k) % NH;
    end
    if (win >= 0) begin
      eg[win] = 1'b1;
      m_last  = win;
      for (int d = ND - 1; d >= 0; d--)
        if ((h_addr[win] & cfg_mask[d]) == cfg_base[d]) dv = d;
      m_busy = 1; m_host = win; m_we = h_we[win];
      if (dv < 0) begin
        m_done = cyc + 1; m_err = 1; m_data = '0;
      end else begin
        edr[dv] = 1'b1;
        if (lat[dv] >= 1 && lat[dv] < TO) begin
          m_done = cyc + lat[dv];
          m_err  = (dv == 1) ? h_addr[win][2] : 1'b0;
          m_data = (dv == 1) ? ~h_addr[win] : ram_data(h_addr[win]);
        end else begin
          m_done = cyc + TO; m_err = 1; m_data = '0;
        end
      end
    end else if (rsp) begin
      m_busy = 0;
    end
    chk("gnt", 64'(host_gnt), 64'(eg));
    chk("dreq", 64'(device_req), 64'(edr));
    for (int d = 0; d < ND; d++) begin
      if (edr[d]) begin
        chk("dfwd", {d_addr[d], d_wdata[d]}, {h_addr[win], h_wdata[win]});
        chk("dctl", 64'({d_we[d], d_be[d]}), 64'({h_we[win], h_be[win]}));
      end else begin
        chk("didle", {d_addr[d], d_wdata[d]}, 64'(0));
        chk("didlectl", 64'({d_we[d], d_be[d]}), 64'(0));
      end
    end
    chk("rvalid", 64'(host_rvalid), 64'(erv));
    if (rsp) begin
      chk("rsp_err", 64'(host_err[rh]), 64'(rerr));
      if (!rwe) chk("rsp_data", 64'(host_rdata[rh]), 64'(rdat));
    end
    m_ready = 1;
    cyc++;
  endtask

  task automatic tick_end();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    host_req = '0;
    repeat (n) begin
      tick_begin();
      tick_end();
    end
  endtask

  task automatic new_fields(input int h);
    case ($urandom_range(0, 3))
      0, 1:    h_addr[h] = {16'h0, 16'($urandom) & 16'hFFFC};
      2:       h_addr[h] = 32'h2000_0000 | ($urandom & 32'hFFC);
      default: h_addr[h] = 32'h4000_0000 | $urandom;
    endcase
    h_we[h]    = 1'($urandom_range(0, 1));
    h_be[h]    = 4'($urandom);
    h_wdata[h] = $urandom;
  endtask

  typedef struct {
    int          host;
    logic [31:0] addr;
    logic [31:0] base1;
    logic [31:0] mask1;
    logic [1:0]  dreq;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt [8];
  logic [NH-1:0] seq_g  [5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
  logic [NH-1:0] seq_rv [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b001};
  logic [AW-1:0] gaddr [NH];
  logic [NH-1:0] oh;

  initial begin
    vt[0] = '{0, 32'h0000_0010, 32'h2000_0000, 32'hFFFF_F000, 2'b01, 1'b0, 32'h0000_1264};
    vt[1] = '{1, 32'h0001_0000, 32'h2000_0000, 32'hFFFF_F000, 2'b00, 1'b1, 32'h0000_0000};
    vt[2] = '{2, 32'h2000_0004, 32'h2000_0000, 32'hFFFF_F000, 2'b10, 1'b1, 32'hDFFF_FFFB};
    vt[3] = '{0, 32'h2000_0008, 32'h2000_0000, 32'hFFFF_F000, 2'b10, 1'b0, 32'hDFFF_FFF7};
    vt[4] = '{1, 32'h2000_1000, 32'h2000_0000, 32'hFFFF_F000, 2'b00, 1'b1, 32'h0000_0000};
    vt[5] = '{2, 32'h0000_0010, 32'h0000_0000, 32'hFFFF_FC00, 2'b01, 1'b0, 32'h0000_1264};
    vt[6] = '{0, 32'h0000_03FC, 32'h0000_0000, 32'hFFFF_FC00, 2'b01, 1'b0, 32'h0000_1E28};
    vt[7] = '{1, 32'h0001_0020, 32'h0001_0000, 32'hFFFF_0000, 2'b10, 1'b0, 32'hFFFE_FFDF};

    rst_ni = 1'b0;
    host_req = '0;
    h_we = '0;
    for (int h = 0; h < NH; h++) begin
      h_addr[h] = 32'h40 + 32'(h) * 32'h100;
      h_be[h] = 4'hF;
      h_wdata[h] = '0;
      gaddr[h] = '0;
    end
    cfg_base[0] = 32'h0; cfg_mask[0] = 32'hFFFF_0000;
    cfg_base[1] = 32'h2000_0000; cfg_mask[1] = 32'hFFFF_F000;
    lat[0] = 1; lat[1] = 1;
    @(posedge clk);
    #1;

    // Reset with all hosts requesting, release, then continuous round-robin.
    host_req = 3'b111;
    repeat (2) begin tick_begin(); tick_end(); end
    rst_ni = 1'b1;
    tick_begin();
    chk("ready_gnt", 64'(host_gnt), 64'(0));
    tick_end();
    for (int i = 0; i < 5; i++) begin
      tick_begin();
      chk("rr_gnt", 64'(host_gnt), 64'(seq_g[i]));
      chk("rr_rv", 64'(host_rvalid), 64'(seq_rv[i]));
      for (int h = 0; h < NH; h++)
        if (seq_rv[i][h]) chk("rr_own_data", 64'(host_rdata[h]), 64'(ram_data(gaddr[h])));
      tick_end();
      for (int h = 0; h < NH; h++)
        if (seq_g[i][h]) begin
          gaddr[h] = h_addr[h];
          h_addr[h] = h_addr[h] + 32'd4;
        end
    end
    drain(3);

    for (int i = 0; i < 8; i++) begin
      drain(2);
      cfg_base[1] = vt[i].base1;
      cfg_mask[1] = vt[i].mask1;
      oh = '0;
      oh[vt[i].host] = 1'b1;
      host_req = oh;
      h_addr[vt[i].host] = vt[i].addr;
      h_we[vt[i].host] = 1'b0;
      tick_begin();
      chk("vec_gnt", 64'(host_gnt), 64'(oh));
      chk("vec_dreq", 64'(device_req), 64'(vt[i].dreq));
      tick_end();
      host_req = '0;
      tick_begin();
      chk("vec_rvalid", 64'(host_rvalid), 64'(oh));
      chk("vec_err", 64'(host_err[vt[i].host]), 64'(vt[i].err));
      chk("vec_rdata", 64'(host_rdata[vt[i].host]), 64'(vt[i].rdata));
      tick_end();
    end
    cfg_base[1] = 32'h2000_0000; cfg_mask[1] = 32'hFFFF_F000;
    drain(2);

    // Round-robin pointer at host 0: hosts 0 and 2 compete.
    host_req = 3'b001; h_addr[0] = 32'h20;
    tick_begin(); chk("rr0_gnt", 64'(host_gnt), 64'(3'b001)); tick_end();
    host_req = 3'b101; h_addr[0] = 32'h24; h_addr[2] = 32'h30;
    tick_begin(); chk("rr2_gnt", 64'(host_gnt), 64'(3'b100)); tick_end();
    host_req = 3'b001;
    tick_begin(); chk("rr0b_gnt", 64'(host_gnt), 64'(3'b001)); tick_end();
    drain(3);

    // Silent device: timeout after TO cycles, next host granted in the same cycle.
    lat[1] = 0;
    host_req = 3'b001; h_addr[0] = 32'h2000_0010; h_we[0] = 1'b0;
    tick_begin();
    chk("to_gnt", 64'(host_gnt), 64'(3'b001));
    chk("to_dreq", 64'(device_req), 64'(2'b10));
    tick_end();
    host_req = 3'b010; h_addr[1] = 32'h80; h_we[1] = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick_begin();
      chk("to_wait_gnt", 64'(host_gnt), 64'(0));
      chk("to_wait_rv", 64'(host_rvalid), 64'(0));
      tick_end();
    end
    tick_begin();
    chk("to_rv", 64'(host_rvalid), 64'(3'b001));
    chk("to_err", 64'(host_err[0]), 64'(1));
    chk("to_rdata", 64'(host_rdata[0]), 64'(0));
    chk("to_next_gnt", 64'(host_gnt), 64'(3'b010));
    tick_end();
    host_req = '0;
    tick_begin(); chk("to_next_rv", 64'(host_rvalid), 64'(3'b010)); tick_end();
    drain(2);

    // Reset while waiting on the silent device.
    host_req = 3'b001; h_addr[0] = 32'h2000_0020;
    tick_begin(); tick_end();
    host_req = '0;
    tick_begin(); tick_end();
    rst_ni = 1'b0;
    host_req = 3'b111;
    for (int h = 0; h < NH; h++) h_addr[h] = 32'h100 + 32'(h) * 32'h10;
    repeat (2) begin tick_begin(); tick_end(); end
    rst_ni = 1'b1;
    tick_begin();
    chk("rel_gnt", 64'(host_gnt), 64'(0));
    chk("rel_rv", 64'(host_rvalid), 64'(0));
    tick_end();
    tick_begin(); chk("rel_first", 64'(host_gnt), 64'(3'b001)); tick_end();
    drain(3);

    // Random traffic: responding slow device, then silent device.
    for (int phase = 0; phase < 2; phase++) begin
      lat[1] = (phase == 0) ? 2 : 0;
      for (int i = 0; i < ((phase == 0) ? 400 : 200); i++) begin
        tick_begin();
        tick_end();
        for (int h = 0; h < NH; h++) begin
          if (host_req[h] && last_gnt[h]) begin
            host_req[h] = 1'($urandom_range(0, 1));
            if (host_req[h]) new_fields(h);
          end else if (!host_req[h] && $urandom_range(0, 2) == 0) begin
            host_req[h] = 1'b1;
            new_fields(h);
          end
        end
      end
      drain(TO + 3);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Round-robin, single-outstanding bus interconnect between N hosts (core instruction port, core data port, test utility) and M address-mapped devices (RAM, test utility device) in the simulation top. It arbitrates fairly between requesting hosts, decodes the granted address against per-device base/mask pairs and issues the request to one device. It routes the device response back to the granted host, and generates error responses for unmapped addresses and for devices that fail to respond.

## Interface
- NrHosts, 3: number of hosts; index 0..NrHosts-1.
- NrDevices, 2: number of devices.
- DataWidth, 32: data width.
- AddressWidth, 32: address width.
- TimeoutCycles, 255: WAIT cycles without device_rvalid_i before a timeout error; legal range 2..65535.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- host_req_i  in  1 [NrHosts]  request; held until granted.
- host_gnt_o  out  1 [NrHosts]  grant; one-hot or zero.
- host_addr_i / host_we_i / host_be_i / host_wdata_i  in  AddressWidth / 1 / DataWidth/8 / DataWidth [NrHosts]  request fields.
- host_rvalid_o  out  1 [NrHosts]  response valid.
- host_rdata_o  out  DataWidth [NrHosts]  response data.
- host_err_o  out  1 [NrHosts]  response error.
- device_req_o  out  1 [NrDevices]  device request; one-hot or zero.
- device_addr_o / device_we_o / device_be_o / device_wdata_o  out  same widths [NrDevices]  forwarded fields.
- device_rvalid_i / device_rdata_i / device_err_i  in  1 / DataWidth / 1 [NrDevices]  device response.
- cfg_device_addr_base / cfg_device_addr_mask  in  AddressWidth [NrDevices]  address map; quasi-static.

## Operation
- States: IDLE, WAIT. A one-bit flop `ready_q` resets to 0 and sets to 1 on the first clock edge after reset release. No grant while `ready_q` = 0.
- Grant condition: `ready_q` & (IDLE | (WAIT & response completes this cycle)).
- Arbitration: `rr_q` holds the last granted host index; reset value NrHosts-1, so host 0 wins first. The candidate order is rr_q+1, rr_q+2, … modulo NrHosts, and the first requester in that order wins. On a grant, `rr_q` becomes the winner.
- Decode: device d matches when (addr & mask[d]) == base[d]. When several devices match, the lowest d wins.
- On a grant with a match: device_req_o[d] = 1 and the winner's fields are forwarded. Register `host_q`, `dev_q`, `derr_q` = 0, clear `cnt_q`, then go to WAIT.
- On a grant with no match: no device_req. Register `derr_q` = 1, then go to WAIT.
- Non-requested devices: device_req_o = 0; addr/we/be/wdata = 0.
- WAIT with `derr_q` = 1: this cycle, assert host_rvalid_o[host_q] = 1, host_err_o = 1, host_rdata_o = 0. The response completes.
- WAIT with `derr_q` = 0 and device_rvalid_i[dev_q] = 1: host_rvalid_o[host_q] = 1, with rdata and err passed through combinationally. The response completes.
- WAIT otherwise: `cnt_q` increments. When `cnt_q` == TimeoutCycles-1, return rvalid = 1, err = 1, rdata = 0 to host_q. The response completes.
- Response completes with no new grant: go to IDLE.
- Response completes with a new grant in the same cycle: stay in WAIT and reload `host_q`, `dev_q`, `derr_q` and `cnt_q`.
- Device rvalid outside WAIT, or from a device ≠ dev_q: ignored.
- TimeoutCycles must exceed every device's maximum latency. Late responses after a timeout are unsupported.
- Writes receive a response exactly like reads (rvalid, rdata don't-care).

## Timing
- Reset values: state = IDLE, ready_q = 0, rr_q = NrHosts-1, host_q = 0, dev_q = 0, derr_q = 0, cnt_q = 0.
- During reset and while ready_q = 0: all gnt, device_req and rvalid outputs are 0, and all data/err outputs are 0.
- host_gnt_o and device_req_o are combinational from host_req_i in the same cycle (cycle N).
- Response from a 1-cycle-latency device (ram_1p): host_rvalid_o in cycle N+1. A new grant is possible in N+1, giving back-to-back throughput of 1 per cycle.
- Decode error: rvalid/err in cycle N+1.
- Timeout: error rvalid in cycle N+TimeoutCycles.
- Reset asserted mid-transaction: the transaction is abandoned and no response is produced. The first grant is possible in the second cycle after reset release.
- cnt_q width: $clog2(TimeoutCycles) bits; it never wraps.

## Structure
- Package `bus_arb_pkg` holds `bus_arb_state_e` (IDLE, WAIT).
- Sub-module `rr_pick` holds the combinational round-robin picker: inputs req vector and last index; outputs valid and winner index, parameterised by N.
- Decode, response mux, timeout counter and FSM stay in the top module.

## Test plan
- Three hosts request continuously, RAM at 0x0 returns rvalid N+1 → grants cycle 0,1,2 in order 0,1,2, then 0, with each host receiving exactly its own rdata.
- Host 1 reads 0x0001_0000, which is unmapped with a 64 kB RAM → no device_req; host_rvalid_o[1] = 1, err = 1, rdata = 0 in N+1.
- Device stub never responds, TimeoutCycles = 4 → err response at N+4, then the next pending host is granted in the same cycle.
- Hosts 0 and 2 request while rr_q = 0 → host 2 granted; next cycle host 0 granted.
- Overlapping map: base0 = 0x0/mask ~0xFFFF, base1 = 0x0/mask ~0x3FF, address 0x10 → device 0 selected.
- rst_ni low while in WAIT → no response emitted; after release, gnt stays 0 for one cycle, then host 0 wins first.
